// File: rtl/rgmii_rx_pkg.sv
// Shared definitions for the RGMII receive unpacker: state encoding, framing
// constants and CRC-32 constants used by both the receive path and the CRC core.
package rgmii_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_CNT,
        ST_DATA,
        ST_TAIL,
        ST_SKIP,
        ST_DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam int          HDR_LEN     = 14;
    localparam int          WORD_BYTES  = 5;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state logic, LSB of the byte enters first.
// Shared with the transmit side so both ends agree on bit ordering.
module crc32_d8
    import rgmii_rx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_crc
);

    always_comb begin : crcStep
        logic [31:0] c;
        c = i_crc ^ {24'd0, i_byte};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        o_crc = c;
    end

endmodule

// File: rtl/rgmii_rx_unpack.sv
// RGMII receive unpacker: preamble/SFD detection, DA/EtherType filtering,
// 40-bit word recovery toward the DAC FIFO and FCS check with per-frame status.
module rgmii_rx_unpack
    import rgmii_rx_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter bit          CHECK_DA  = 1'b1,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MAX_WORDS = 299
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic        full,
    output logic [39:0] odata,
    output logic        wren,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic [15:0] ok_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] ovf_cnt
);

    rx_state_t   r_state;
    logic        r_dvPrev;
    logic [31:0] r_crc;
    logic        r_bad;
    logic [2:0]  r_preCnt;
    logic [3:0]  r_hdrCnt;
    logic        r_daUni;
    logic        r_daBcast;
    logic        r_etHiOk;
    logic        r_cntIdx;
    logic [15:0] r_wcnt;
    logic [15:0] r_wordCnt;
    logic [2:0]  r_byteIdx;
    logic [31:0] r_shift;
    logic [2:0]  r_tailCnt;

    logic [31:0] w_crcNext;
    logic [7:0]  w_daByte;
    logic [15:0] w_wcnt;
    logic        w_inFrame;
    logic        w_good;

    crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_byte (rx_byte),
        .o_crc  (w_crcNext)
    );

    always_comb begin
        w_daByte = 8'h00;
        case (r_hdrCnt)
            4'd0:    w_daByte = MAC_ADDR[47:40];
            4'd1:    w_daByte = MAC_ADDR[39:32];
            4'd2:    w_daByte = MAC_ADDR[31:24];
            4'd3:    w_daByte = MAC_ADDR[23:16];
            4'd4:    w_daByte = MAC_ADDR[15:8];
            4'd5:    w_daByte = MAC_ADDR[7:0];
            default: w_daByte = 8'h00;
        endcase
    end

    assign w_wcnt    = {r_wcnt[15:8], rx_byte};
    assign w_inFrame = (r_state == ST_HDR) || (r_state == ST_CNT) || (r_state == ST_DATA) ||
                       (r_state == ST_TAIL) || (r_state == ST_SKIP);
    assign w_good    = !r_bad && (r_state == ST_TAIL) && (r_tailCnt >= 3'd4) &&
                       (r_crc == CRC_RESIDUE);

    // dv_prev resets high so a frame already in flight at reset release is dropped.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dvPrev  <= 1'b1;
            r_crc     <= CRC_INIT;
            r_bad     <= 1'b0;
            r_preCnt  <= 3'd0;
            r_hdrCnt  <= 4'd0;
            r_daUni   <= 1'b0;
            r_daBcast <= 1'b0;
            r_etHiOk  <= 1'b0;
            r_cntIdx  <= 1'b0;
            r_wcnt    <= 16'd0;
            r_wordCnt <= 16'd0;
            r_byteIdx <= 3'd0;
            r_shift   <= 32'd0;
            r_tailCnt <= 3'd0;
            odata     <= 40'd0;
            wren      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_bad <= 1'b0;
            ok_cnt    <= 16'd0;
            bad_cnt   <= 16'd0;
            ovf_cnt   <= 16'd0;
        end else begin
            r_dvPrev  <= rx_dv;
            wren      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_bad <= 1'b0;
            if (!rx_dv) begin
                if (w_inFrame) begin
                    frame_ok  <= w_good;
                    frame_bad <= !w_good;
                    if (w_good) ok_cnt  <= satInc(ok_cnt);
                    else        bad_cnt <= satInc(bad_cnt);
                end
                r_state <= ST_IDLE;
            end else if (rx_er && (r_state == ST_HDR || r_state == ST_CNT ||
                                   r_state == ST_DATA || r_state == ST_TAIL)) begin
                r_bad   <= 1'b1;
                r_state <= ST_SKIP;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dvPrev && rx_byte == PREAMBLE) begin
                            r_state  <= ST_PRE;
                            r_preCnt <= 3'd1;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                    ST_PRE: begin
                        if (rx_byte == PREAMBLE) begin
                            if (r_preCnt == 3'd7) r_state <= ST_DROP;
                            else                  r_preCnt <= r_preCnt + 3'd1;
                        end else if (rx_byte == SFD) begin
                            r_state   <= ST_HDR;
                            r_crc     <= CRC_INIT;
                            r_bad     <= 1'b0;
                            r_hdrCnt  <= 4'd0;
                            r_daUni   <= 1'b1;
                            r_daBcast <= 1'b1;
                            r_etHiOk  <= 1'b0;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                    ST_HDR: begin
                        r_crc    <= w_crcNext;
                        r_hdrCnt <= r_hdrCnt + 4'd1;
                        if (r_hdrCnt < 4'd6) begin
                            if (rx_byte != w_daByte) r_daUni   <= 1'b0;
                            if (rx_byte != 8'hFF)    r_daBcast <= 1'b0;
                        end
                        if (r_hdrCnt == 4'd12) r_etHiOk <= (rx_byte == ETHERTYPE[15:8]);
                        // Filter verdict waits for the last EtherType byte.
                        if (r_hdrCnt == 4'(HDR_LEN - 1)) begin
                            if ((CHECK_DA && !r_daUni && !r_daBcast) || !r_etHiOk ||
                                (rx_byte != ETHERTYPE[7:0])) begin
                                r_bad   <= 1'b1;
                                r_state <= ST_SKIP;
                            end else begin
                                r_state  <= ST_CNT;
                                r_cntIdx <= 1'b0;
                            end
                        end
                    end
                    ST_CNT: begin
                        r_crc <= w_crcNext;
                        if (!r_cntIdx) begin
                            r_wcnt[15:8] <= rx_byte;
                            r_cntIdx     <= 1'b1;
                        end else begin
                            r_wcnt <= w_wcnt;
                            if (w_wcnt > 16'(MAX_WORDS)) begin
                                r_bad   <= 1'b1;
                                r_state <= ST_SKIP;
                            end else if (w_wcnt == 16'd0) begin
                                r_state   <= ST_TAIL;
                                r_tailCnt <= 3'd0;
                            end else begin
                                r_state   <= ST_DATA;
                                r_byteIdx <= 3'd0;
                                r_wordCnt <= 16'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        r_crc   <= w_crcNext;
                        r_shift <= {r_shift[23:0], rx_byte};
                        if (r_byteIdx == 3'(WORD_BYTES - 1)) begin
                            r_byteIdx <= 3'd0;
                            if (full) begin
                                ovf_cnt <= satInc(ovf_cnt);
                            end else begin
                                odata <= {r_shift, rx_byte};
                                wren  <= 1'b1;
                            end
                            r_wordCnt <= r_wordCnt + 16'd1;
                            if (r_wordCnt + 16'd1 == r_wcnt) begin
                                r_state   <= ST_TAIL;
                                r_tailCnt <= 3'd0;
                            end
                        end else begin
                            r_byteIdx <= r_byteIdx + 3'd1;
                        end
                    end
                    ST_TAIL: begin
                        r_crc <= w_crcNext;
                        if (r_tailCnt != 3'd4) r_tailCnt <= r_tailCnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_unpack.sv
// Self-checking bench for rgmii_rx_unpack: directed frames from the test plan
// followed by randomized frames, all judged by a frame-level reference model.
module tb_rgmii_rx_unpack;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam int          MAXW  = 299;

    logic        rxclk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_dv;
    logic        rx_er;
    logic        full;
    logic [39:0] odata;
    logic        wren;
    logic        frame_ok;
    logic        frame_bad;
    logic [15:0] ok_cnt;
    logic [15:0] bad_cnt;
    logic [15:0] ovf_cnt;

    rgmii_rx_unpack #(
        .MAC_ADDR  (MAC),
        .CHECK_DA  (1'b1),
        .ETHERTYPE (ETYPE),
        .MAX_WORDS (MAXW)
    ) dut (
        .rxclk     (rxclk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .full      (full),
        .odata     (odata),
        .wren      (wren),
        .frame_ok  (frame_ok),
        .frame_bad (frame_bad),
        .ok_cnt    (ok_cnt),
        .bad_cnt   (bad_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    always #4 rxclk = ~rxclk;

    // Everything the DUT emits is logged here; the checker reads it by index.
    logic [39:0] obsWords[$];
    int          obsOk = 0;
    int          obsBad = 0;

    always @(negedge rxclk) begin
        if (wren)      obsWords.push_back(odata);
        if (frame_ok)  obsOk++;
        if (frame_bad) obsBad++;
    end

    logic [7:0]  txBytes[$];
    bit          erQ[$];
    bit          fullQ[$];
    logic [39:0] wordsIn[$];
    logic [39:0] expWords[$];
    int          bodyStart;
    int          obsRd = 0;
    int          expOk = 0;
    int          expBad = 0;
    int          expOkCnt = 0;
    int          expBadCnt = 0;
    int          expOvfCnt = 0;
    int          nTotal = 0;
    int          nBad = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        nTotal++;
        assert (obs === exp) else begin
            nBad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crcOf(input int from, input int to);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < to; i++) begin
            c = c ^ {24'h0, txBytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic buildFrame(input logic [47:0] da, input logic [15:0] et,
                              input logic [15:0] wcntField, input int padLen,
                              input int preLen, input bit flipFcs);
        logic [31:0] fcs;
        logic [39:0] w;
        txBytes.delete();
        erQ.delete();
        fullQ.delete();
        repeat (preLen) txBytes.push_back(8'h55);
        txBytes.push_back(8'hD5);
        bodyStart = txBytes.size();
        for (int i = 0; i < 6; i++) txBytes.push_back(da[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) txBytes.push_back(8'($urandom));
        txBytes.push_back(et[15:8]);
        txBytes.push_back(et[7:0]);
        txBytes.push_back(wcntField[15:8]);
        txBytes.push_back(wcntField[7:0]);
        foreach (wordsIn[k]) begin
            w = wordsIn[k];
            for (int j = 0; j < 5; j++) txBytes.push_back(w[39 - 8 * j -: 8]);
        end
        for (int i = 0; i < padLen; i++) txBytes.push_back(8'($urandom));
        fcs = ~crcOf(bodyStart, txBytes.size());
        txBytes.push_back(fcs[7:0]);
        txBytes.push_back(fcs[15:8]);
        txBytes.push_back(fcs[23:16]);
        txBytes.push_back(fcs[31:24]);
        if (flipFcs) txBytes[txBytes.size() - 4] = txBytes[txBytes.size() - 4] ^ 8'h10;
        for (int i = 0; i < txBytes.size(); i++) begin
            erQ.push_back(1'b0);
            fullQ.push_back(1'b0);
        end
    endtask

    // Parses the byte stream the way a receiver reads an Ethernet frame and
    // records which words and which status the frame must produce.
    task automatic modelFrame();
        int          pre, s, n, usable, wcnt, last;
        bit          erSeen;
        logic [47:0] da;
        logic [15:0] et;
        logic [39:0] w;
        logic [31:0] fcs;
        pre = 0;
        while (pre < txBytes.size() && txBytes[pre] == 8'h55) pre++;
        if (pre < 1 || pre > 7 || pre >= txBytes.size() || txBytes[pre] != 8'hD5) return;
        s = pre + 1;
        n = txBytes.size() - s;
        usable = n;
        erSeen = 1'b0;
        for (int i = s; i < txBytes.size(); i++) begin
            if (erQ[i]) begin
                usable = i - s;
                erSeen = 1'b1;
                break;
            end
        end
        if (usable < 14) begin expBad++; expBadCnt++; return; end
        da = '0;
        for (int j = 0; j < 6; j++) da = {da[39:0], txBytes[s + j]};
        et = {txBytes[s + 12], txBytes[s + 13]};
        if ((da != MAC && da != BCAST) || et != ETYPE) begin expBad++; expBadCnt++; return; end
        if (usable < 16) begin expBad++; expBadCnt++; return; end
        wcnt = {txBytes[s + 14], txBytes[s + 15]};
        if (wcnt > MAXW) begin expBad++; expBadCnt++; return; end
        for (int k = 0; k < wcnt; k++) begin
            last = 20 + 5 * k;
            if (last >= usable) break;
            if (fullQ[s + last]) begin
                expOvfCnt++;
            end else begin
                w = '0;
                for (int j = 4; j >= 0; j--) w = {w[31:0], txBytes[s + last - j]};
                expWords.push_back(w);
            end
        end
        if (erSeen || usable < 16 + 5 * wcnt + 4) begin expBad++; expBadCnt++; return; end
        fcs = {txBytes[s + n - 1], txBytes[s + n - 2], txBytes[s + n - 3], txBytes[s + n - 4]};
        if (fcs == ~crcOf(s, s + n - 4)) begin expOk++; expOkCnt++; end
        else begin expBad++; expBadCnt++; end
    endtask

    task automatic applyStimulus(input int idle);
        for (int i = 0; i < txBytes.size(); i++) begin
            @(posedge rxclk);
            #1;
            rx_dv   = 1'b1;
            rx_byte = txBytes[i];
            rx_er   = erQ[i];
            full    = fullQ[i];
        end
        repeat (idle) begin
            @(posedge rxclk);
            #1;
            rx_dv   = 1'b0;
            rx_byte = 8'h00;
            rx_er   = 1'b0;
            full    = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        repeat (3) @(negedge rxclk);
        #1;
        check({tag, "/nwords"}, 40'(obsWords.size() - obsRd), 40'(expWords.size()));
        while (obsRd < obsWords.size() && expWords.size() > 0) begin
            check({tag, "/word"}, obsWords[obsRd], expWords.pop_front());
            obsRd++;
        end
        obsRd = obsWords.size();
        expWords.delete();
        check({tag, "/okPulses"},  40'(obsOk),   40'(expOk));
        check({tag, "/badPulses"}, 40'(obsBad),  40'(expBad));
        check({tag, "/ok_cnt"},    40'(ok_cnt),  40'(expOkCnt));
        check({tag, "/bad_cnt"},   40'(bad_cnt), 40'(expBadCnt));
        check({tag, "/ovf_cnt"},   40'(ovf_cnt), 40'(expOvfCnt));
    endtask

    task automatic loadPlanWords();
        wordsIn.delete();
        wordsIn.push_back(40'h01_2345_6789);
        wordsIn.push_back(40'hAA_BBCC_DDEE);
        wordsIn.push_back(40'h00_0000_0001);
    endtask

    initial begin
        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        rx_er   = 1'b0;
        full    = 1'b0;
        repeat (3) @(negedge rxclk);
        check("rst/odata",     odata,            40'd0);
        check("rst/wren",      40'(wren),        40'd0);
        check("rst/frame_ok",  40'(frame_ok),    40'd0);
        check("rst/frame_bad", 40'(frame_bad),   40'd0);
        check("rst/counters",  {ok_cnt[7:0], bad_cnt, ovf_cnt}, 40'd0);
        @(posedge rxclk);
        #1 reset = 1'b0;
        repeat (3) @(posedge rxclk);

        $display("[TB] good frame");
        loadPlanWords();
        buildFrame(MAC, ETYPE, 16'd3, 40, 7, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("good");

        $display("[TB] FCS bit error");
        buildFrame(MAC, ETYPE, 16'd3, 40, 7, 1'b1);
        modelFrame();
        applyStimulus(4);
        checkOutput("fcsErr");

        $display("[TB] rx_er during word 2");
        buildFrame(MAC, ETYPE, 16'd3, 40, 7, 1'b0);
        erQ[bodyStart + 23] = 1'b1;
        modelFrame();
        applyStimulus(4);
        checkOutput("rxEr");

        $display("[TB] oversize WCNT");
        wordsIn.delete();
        buildFrame(MAC, ETYPE, 16'd300, 20, 7, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("oversize");

        $display("[TB] wrong DA, then broadcast DA");
        loadPlanWords();
        buildFrame(48'h02_00_00_00_00_02, ETYPE, 16'd3, 10, 7, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("daMiss");
        buildFrame(BCAST, ETYPE, 16'd3, 10, 3, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("bcast");

        $display("[TB] full during word 2");
        buildFrame(MAC, ETYPE, 16'd3, 8, 7, 1'b0);
        for (int i = 21; i <= 25; i++) fullQ[bodyStart + i] = 1'b1;
        modelFrame();
        applyStimulus(4);
        checkOutput("full");

        $display("[TB] reset mid-DATA");
        buildFrame(MAC, ETYPE, 16'd3, 8, 7, 1'b0);
        for (int i = 0; i < txBytes.size(); i++) begin
            @(posedge rxclk);
            #1;
            rx_dv   = 1'b1;
            rx_byte = txBytes[i];
            reset   = (i == bodyStart + 23);
        end
        repeat (4) begin
            @(posedge rxclk);
            #1;
            rx_dv = 1'b0;
            reset = 1'b0;
        end
        expWords.push_back(wordsIn[0]);
        expOkCnt  = 0;
        expBadCnt = 0;
        expOvfCnt = 0;
        checkOutput("midReset");

        buildFrame(MAC, ETYPE, 16'd3, 5, 7, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("afterReset");

        $display("[TB] back-to-back frames, one idle cycle");
        wordsIn.delete();
        wordsIn.push_back({8'($urandom), $urandom});
        buildFrame(MAC, ETYPE, 16'd1, 0, 7, 1'b0);
        modelFrame();
        applyStimulus(1);
        buildFrame(MAC, ETYPE, 16'd1, 2, 1, 1'b0);
        modelFrame();
        applyStimulus(4);
        checkOutput("b2b");

        $display("[TB] random frames");
        for (int f = 0; f < 12; f++) begin
            int          nW, pad, pre, idle, pick, r;
            logic [47:0] da;
            logic [15:0] et, wf;
            bit          flip;
            nW = $urandom_range(0, 6);
            wordsIn.delete();
            repeat (nW) wordsIn.push_back({8'($urandom), $urandom});
            pick = $urandom_range(0, 9);
            da = (pick < 6) ? MAC : (pick < 8) ? BCAST :
                 (pick == 8) ? 48'h02_00_00_00_00_02 : {16'($urandom), $urandom};
            et = ($urandom_range(0, 7) == 0) ? 16'h0800 : ETYPE;
            r  = $urandom_range(0, 9);
            wf = (r == 0) ? 16'(nW + 1) : (r == 1) ? 16'(300 + $urandom_range(0, 50)) : 16'(nW);
            pad  = $urandom_range(0, 12);
            pre  = $urandom_range(1, 8);
            flip = ($urandom_range(0, 3) == 0);
            buildFrame(da, et, wf, pad, pre, flip);
            for (int i = 0; i < txBytes.size(); i++) fullQ[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) erQ[$urandom_range(bodyStart, txBytes.size() - 1)] = 1'b1;
            modelFrame();
            idle = $urandom_range(1, 3);
            applyStimulus(idle);
            if (idle > 1) checkOutput("rand");
        end
        checkOutput("randEnd");

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
